// File: rtl/uop_sequencer.sv
// Micro-op sequencer: buffers one decoded instruction (up to three micro-ops)
// and issues its steps to the execute stage, final step (uop_0) last.
module uop_sequencer (
    input  logic        clk,
    input  logic        a_rst,
    input  logic        hold,
    input  logic        flush,
    input  logic        feed_ack,
    input  logic [19:0] uop_0,
    input  logic [19:0] uop_1,
    input  logic [19:0] uop_2,
    input  logic [1:0]  uop_count,
    input  logic        exec_ready,
    output logic        feed_req,
    output logic [19:0] uop,
    output logic        uop_valid,
    output logic        uop_last,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        wr_flags,
    output logic        retired
);

    // Handshakes: an instruction transfers when feed_req & feed_ack; a micro-op
    // transfers when uop_valid & exec_ready (both suppressed by hold/flush).
    logic [19:0] buf0_q, buf1_q, buf2_q;
    logic [19:0] buf0_d, buf1_d, buf2_d;
    logic [1:0]  rem_q, rem_d;
    logic        fire;
    logic        capture;

    always_comb begin
        uop_valid = (rem_q != 2'd0);
        uop_last  = (rem_q == 2'd1);
        case (rem_q)
            2'd3:    uop = buf2_q;
            2'd2:    uop = buf1_q;
            2'd1:    uop = buf0_q;
            default: uop = 20'h0;
        endcase
        mem_rd   = uop_valid & uop[14];
        mem_wr   = uop_valid & uop[13];
        wr_flags = uop_valid & uop[12];

        fire     = uop_valid & exec_ready & ~hold & ~flush;
        retired  = fire & uop_last;
        // Accepting at rem=1 with exec_ready lets the next instruction follow with no bubble.
        feed_req = ~hold & ~flush & ((rem_q == 2'd0) | ((rem_q == 2'd1) & exec_ready));
        capture  = feed_req & feed_ack;
    end

    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        buf2_d = buf2_q;
        rem_d  = rem_q;
        if (!hold) begin
            if (flush) begin
                rem_d = 2'd0;
            end else if (capture) begin
                buf0_d = uop_0;
                buf1_d = uop_1;
                buf2_d = uop_2;
                case (uop_count)
                    2'd0:    rem_d = 2'd1;
                    2'd1:    rem_d = 2'd2;
                    default: rem_d = 2'd3;
                endcase
            end else if (fire) begin
                rem_d = rem_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!a_rst) begin
            buf0_q <= 20'h0;
            buf1_q <= 20'h0;
            buf2_q <= 20'h0;
            rem_q  <= 2'd0;
        end else begin
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
            buf2_q <= buf2_d;
            rem_q  <= rem_d;
        end
    end

endmodule

// File: tb/tb_uop_sequencer.sv
// Bench for uop_sequencer: directed scenarios then random traffic, all checked
// against a queue-of-pending-micro-ops reference model.
module tb_uop_sequencer;

    logic        clk;
    logic        a_rst;
    logic        hold;
    logic        flush;
    logic        feed_ack;
    logic [19:0] uop_0, uop_1, uop_2;
    logic [1:0]  uop_count;
    logic        exec_ready;
    logic        feed_req;
    logic [19:0] uop;
    logic        uop_valid;
    logic        uop_last;
    logic        mem_rd;
    logic        mem_wr;
    logic        wr_flags;
    logic        retired;

    uop_sequencer dut (
        .clk        (clk),
        .a_rst      (a_rst),
        .hold       (hold),
        .flush      (flush),
        .feed_ack   (feed_ack),
        .uop_0      (uop_0),
        .uop_1      (uop_1),
        .uop_2      (uop_2),
        .uop_count  (uop_count),
        .exec_ready (exec_ready),
        .feed_req   (feed_req),
        .uop        (uop),
        .uop_valid  (uop_valid),
        .uop_last   (uop_last),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .wr_flags   (wr_flags),
        .retired    (retired)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: micro-ops still to issue for the buffered instruction, in issue order
    logic [19:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_feed_req();
        return !hold && !flush && (exp_q.size() == 0 || (exp_q.size() == 1 && exec_ready));
    endfunction

    task automatic check_outputs();
        logic [19:0] e_uop;
        logic        e_valid;
        logic        e_fire;
        e_valid = (exp_q.size() != 0);
        e_uop   = e_valid ? exp_q[0] : 20'h0;
        e_fire  = e_valid && exec_ready && !hold && !flush;
        check("uop",       32'(uop),       32'(e_uop));
        check("uop_valid", 32'(uop_valid), 32'(e_valid));
        check("uop_last",  32'(uop_last),  32'(exp_q.size() == 1));
        check("mem_rd",    32'(mem_rd),    32'(e_valid && e_uop[14]));
        check("mem_wr",    32'(mem_wr),    32'(e_valid && e_uop[13]));
        check("wr_flags",  32'(wr_flags),  32'(e_valid && e_uop[12]));
        check("retired",   32'(retired),   32'(e_fire && exp_q.size() == 1));
        check("feed_req",  32'(feed_req),  32'(model_feed_req()));
    endtask

    task automatic model_update();
        logic m_fire, m_cap;
        m_fire = (exp_q.size() != 0) && exec_ready && !hold && !flush;
        m_cap  = model_feed_req() && feed_ack;
        if (!a_rst) exp_q.delete();
        else if (hold) ;
        else if (flush) exp_q.delete();
        else begin
            if (m_fire) void'(exp_q.pop_front());
            if (m_cap) begin
                exp_q.delete();
                if (uop_count >= 2'd2) exp_q.push_back(uop_2);
                if (uop_count >= 2'd1) exp_q.push_back(uop_1);
                exp_q.push_back(uop_0);
            end
        end
    endtask

    // driver: apply inputs at negedge, check, then advance the model at the edge
    task automatic cycle(input logic rst_n, input logic h, input logic f, input logic ack,
                         input logic er, input logic [1:0] cnt,
                         input logic [19:0] u0, input logic [19:0] u1, input logic [19:0] u2);
        a_rst = rst_n; hold = h; flush = f; feed_ack = ack; exec_ready = er;
        uop_count = cnt; uop_0 = u0; uop_1 = u1; uop_2 = u2;
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(input logic er);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, er, 2'd0, 20'h0, 20'h0, 20'h0);
    endtask

    task automatic load(input logic [1:0] cnt, input logic [19:0] u0, input logic [19:0] u1,
                        input logic [19:0] u2);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, cnt, u0, u1, u2);
    endtask

    initial begin
        a_rst = 1'b0; hold = 1'b0; flush = 1'b0; feed_ack = 1'b1; exec_ready = 1'b1;
        uop_count = 2'd2; uop_0 = 20'hFFFFF; uop_1 = 20'hFFFFF; uop_2 = 20'hFFFFF;
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        // reset held low with an ack present: nothing may be captured
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 20'h11111, 20'h22222, 20'h33333);
        check("rst_valid", 32'(uop_valid), 32'd0);
        check("rst_uop",   32'(uop),       32'd0);

        // single step
        load(2'd0, 20'h7A0C1, 20'h0, 20'h0);
        check("single_uop",  32'(uop),      32'h7A0C1);
        check("single_last", 32'(uop_last), 32'd1);
        idle(1'b1);

        // three steps, then back-to-back two-step instruction
        load(2'd2, 20'h00003, 20'h74C0A, 20'h04C0B);
        check("three_c1", 32'(uop), 32'h04C0B);
        check("three_rd", 32'(mem_rd), 32'd1);
        idle(1'b1);
        check("three_c2", 32'(uop), 32'h74C0A);
        idle(1'b1);
        check("three_c3", 32'(uop), 32'h00003);
        check("three_last", 32'(uop_last), 32'd1);
        load(2'd1, 20'h0ABCD, 20'h12345, 20'h0);
        check("b2b_c4", 32'(uop), 32'h12345);
        idle(1'b1);
        check("b2b_c5", 32'(uop), 32'h0ABCD);
        idle(1'b1);

        // backpressure at rem=2
        load(2'd1, 20'h05000, 20'h06000, 20'h0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        check("bp_uop", 32'(uop), 32'h06000);
        idle(1'b1);
        idle(1'b1);

        // flush with a coincident ack
        load(2'd3, 20'h00001, 20'h00002, 20'h00003);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 20'hBEEF0, 20'h0, 20'h0);
        check("flush_valid", 32'(uop_valid), 32'd0);
        idle(1'b1);

        // hold over flush, then reset
        load(2'd2, 20'h0A000, 20'h0B000, 20'h0C000);
        for (int i = 0; i < 2; i++)
            cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 20'h0, 20'h0, 20'h0);
        check("hold_uop", 32'(uop), 32'h0C000);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 20'h0, 20'h0, 20'h0);
        check("rst_mid_valid", 32'(uop_valid), 32'd0);
        idle(1'b1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) >= 2,
                  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < 60,
                  $urandom_range(0, 99) < 70,
                  2'($urandom_range(0, 3)),
                  20'($urandom), 20'($urandom), 20'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
